// File: rtl/uart_loader.sv
// uart_loader: byte-protocol boot loader that writes RAM images, starts the cpu and
// hands it the UART until it halts.
module uart_loader #(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  is_transmitting,
  output logic [7:0]            tx_byte,
  output logic                  transmit,
  output logic [addr_width-1:0] waddr,
  output logic [7:0]            wdata,
  output logic                  write_en,
  output logic [addr_width-1:0] startaddr,
  output logic                  cpu_start,
  input  logic                  cpu_halted,
  output logic                  owns_uart
);
  typedef enum logic [3:0] {
    IDLE, ADDRH, ADDRL, LEN, DATA, GADDRH, GADDRL, START, RUN, TX, GUARD
  } state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d, waddr_q, waddr_d, startaddr_q, startaddr_d;
  logic [8:0]            count_q, count_d;
  logic [7:0]            checksum_q, checksum_d, reply_q, reply_d;
  logic [7:0]            tx_byte_q, tx_byte_d, wdata_q, wdata_d;
  logic                  transmit_q, transmit_d, write_en_q, write_en_d;
  logic                  cpu_start_q, cpu_start_d, owns_uart_q, owns_uart_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    waddr_d     = waddr_q;
    startaddr_d = startaddr_q;
    count_d     = count_q;
    checksum_d  = checksum_q;
    reply_d     = reply_q;
    tx_byte_d   = tx_byte_q;
    wdata_d     = wdata_q;
    owns_uart_d = owns_uart_q;
    transmit_d  = 1'b0;
    write_en_d  = 1'b0;
    cpu_start_d = 1'b0;
    case (state_q)
      IDLE: if (received) begin
        if (rx_byte == 8'h4C) begin
          checksum_d = 8'h00;
          state_d    = ADDRH;
        end else if (rx_byte == 8'h47) begin
          state_d = GADDRH;
        end else begin
          reply_d = 8'h3F;
          state_d = TX;
        end
      end
      ADDRH, GADDRH: if (received) begin
        addr_d  = {rx_byte[addr_width-9:0], 8'h00};
        state_d = (state_q == ADDRH) ? ADDRL : GADDRL;
      end
      ADDRL: if (received) begin
        addr_d  = {addr_q[addr_width-1:8], rx_byte};
        state_d = LEN;
      end
      LEN: if (received) begin
        count_d = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
        state_d = DATA;
      end
      DATA: if (received) begin
        waddr_d    = addr_q;
        wdata_d    = rx_byte;
        write_en_d = 1'b1;
        addr_d     = addr_q + 1'b1;
        checksum_d = checksum_q + rx_byte;
        count_d    = count_q - 9'd1;
        if (count_q == 9'd1) begin
          reply_d = checksum_q + rx_byte;
          state_d = TX;
        end
      end
      GADDRL: if (received) begin
        startaddr_d = {addr_q[addr_width-1:8], rx_byte};
        state_d     = START;
      end
      START: begin
        cpu_start_d = 1'b1;
        owns_uart_d = 1'b0;
        state_d     = RUN;
      end
      // The cpu owns the UART here; only its halt strobe matters.
      RUN: if (cpu_halted) begin
        owns_uart_d = 1'b1;
        reply_d     = 8'h2E;
        state_d     = TX;
      end
      TX: if (!is_transmitting) begin
        tx_byte_d  = reply_q;
        transmit_d = 1'b1;
        state_d    = GUARD;
      end
      GUARD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      waddr_q     <= '0;
      startaddr_q <= '0;
      count_q     <= '0;
      checksum_q  <= '0;
      reply_q     <= '0;
      tx_byte_q   <= '0;
      wdata_q     <= '0;
      transmit_q  <= 1'b0;
      write_en_q  <= 1'b0;
      cpu_start_q <= 1'b0;
      owns_uart_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      waddr_q     <= waddr_d;
      startaddr_q <= startaddr_d;
      count_q     <= count_d;
      checksum_q  <= checksum_d;
      reply_q     <= reply_d;
      tx_byte_q   <= tx_byte_d;
      wdata_q     <= wdata_d;
      transmit_q  <= transmit_d;
      write_en_q  <= write_en_d;
      cpu_start_q <= cpu_start_d;
      owns_uart_q <= owns_uart_d;
    end
  end

  assign tx_byte   = tx_byte_q;
  assign transmit  = transmit_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign write_en  = write_en_q;
  assign startaddr = startaddr_q;
  assign cpu_start = cpu_start_q;
  assign owns_uart = owns_uart_q;
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized protocol scenarios checked against a queue-based model
// of the expected RAM writes and UART replies.
module tb_uart_loader;
  localparam int AW = 9;
  logic          clk = 1'b0, rst = 1'b0, received = 1'b0, is_transmitting = 1'b0, cpu_halted = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [7:0]    tx_byte, wdata;
  logic          transmit, write_en, cpu_start, owns_uart;
  logic [AW-1:0] waddr, startaddr;
  int            n_cmp = 0, n_err = 0, n_start = 0;
  logic [AW+7:0] wr_q[$], exp_q[$];
  logic [7:0]    tx_q[$], data_q[$];

  uart_loader #(.addr_width(AW)) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .waddr(waddr), .wdata(wdata), .write_en(write_en), .startaddr(startaddr),
    .cpu_start(cpu_start), .cpu_halted(cpu_halted), .owns_uart(owns_uart)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_en) wr_q.push_back({waddr, wdata});
    if (transmit) tx_q.push_back(tx_byte);
    if (cpu_start) n_start++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Model: consecutive addresses wrapping mod 2^AW, checksum = byte sum mod 256.
  function automatic logic [7:0] build_exp(input int a);
    logic [7:0] s = 8'h00;
    exp_q.delete();
    foreach (data_q[i]) begin
      exp_q.push_back({AW'((a + i) % (1 << AW)), data_q[i]});
      s += data_q[i];
    end
    return s;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic send_load(input int a);
    logic [7:0] hi;
    hi    = 8'($urandom);
    hi[0] = a[8];
    send(8'h4C);
    send(hi);
    send(8'(a));
    send(8'(data_q.size()));
    foreach (data_q[i]) send(data_q[i]);
  endtask

  task automatic wait_tx(input int lim);
    for (int i = 0; i < lim && tx_q.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_obs();
    wr_q.delete();
    tx_q.delete();
    n_start = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (owns_uart !== 1'b1) begin n_err++; $display("FAIL reset_owns: got %b want 1", owns_uart); end
    n_cmp++; if ({transmit, write_en, cpu_start} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {transmit, write_en, cpu_start}); end
    n_cmp++; if ({tx_byte, wdata} !== 16'h0000) begin n_err++; $display("FAIL reset_bytes: got %h want 0000", {tx_byte, wdata}); end
    n_cmp++; if ({waddr, startaddr} !== '0) begin n_err++; $display("FAIL reset_addrs: got %h want 0", {waddr, startaddr}); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_fixed();
    logic [7:0] ck;
    clear_obs();
    data_q = '{8'h11, 8'h22, 8'h33};
    ck = build_exp(5);
    send_load(5);
    wait_tx(20);
    n_cmp++; if (wr_q.size() != 3) begin n_err++; $display("FAIL fixed_count: got %0d want 3", wr_q.size()); end
    foreach (exp_q[i]) if (i < wr_q.size()) begin
      n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fixed_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); end
    end
    n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'h66 || ck !== 8'h66) begin n_err++; $display("FAIL fixed_reply: got %0d tx first %h want 1 tx 66", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx); end
  endtask

  task automatic test_load_random();
    for (int t = 0; t < 4; t++) begin
      int a, n;
      logic [7:0] ck;
      clear_obs();
      a = $urandom_range(511);
      n = $urandom_range(8, 1);
      data_q.delete();
      for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
      ck = build_exp(a);
      send_load(a);
      wait_tx(20);
      n_cmp++; if (wr_q.size() != n) begin n_err++; $display("FAIL rand_count: got %0d want %0d", wr_q.size(), n); end
      foreach (exp_q[i]) if (i < wr_q.size()) begin
        n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); end
      end
      n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== ck) begin n_err++; $display("FAIL rand_reply: got %0d tx first %h want 1 tx %h", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx, ck); end
    end
  endtask

  task automatic test_wrap_len0();
    logic [7:0] ck;
    clear_obs();
    data_q.delete();
    for (int i = 0; i < 256; i++) data_q.push_back(8'h01);
    ck = build_exp(9'h1FF);
    send_load(9'h1FF);
    wait_tx(20);
    n_cmp++; if (wr_q.size() != 256) begin n_err++; $display("FAIL wrap_count: got %0d want 256", wr_q.size()); end
    foreach (exp_q[i]) if (i < wr_q.size()) begin
      n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); end
    end
    n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== ck) begin n_err++; $display("FAIL wrap_reply: got %0d tx first %h want 1 tx %h", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx, ck); end
  endtask

  task automatic test_run();
    logic [AW-1:0] a;
    logic [7:0] hi;
    clear_obs();
    a     = AW'($urandom);
    hi    = 8'($urandom);
    hi[0] = a[8];
    send(8'h47);
    send(hi);
    send(a[7:0]);
    repeat (3) @(negedge clk);
    n_cmp++; if (startaddr !== a) begin n_err++; $display("FAIL run_startaddr: got %h want %h", startaddr, a); end
    n_cmp++; if (n_start != 1) begin n_err++; $display("FAIL run_start_pulses: got %0d want 1", n_start); end
    n_cmp++; if (owns_uart !== 1'b0) begin n_err++; $display("FAIL run_owns: got %b want 0", owns_uart); end
    send(8'h4C);
    send(8'h00);
    send(8'h12);
    @(negedge clk);
    rx_byte    = 8'h4C;
    received   = 1'b1;
    cpu_halted = 1'b1;
    @(negedge clk);
    received   = 1'b0;
    cpu_halted = 1'b0;
    wait_tx(20);
    n_cmp++; if (wr_q.size() != 0) begin n_err++; $display("FAIL run_writes: got %0d want 0", wr_q.size()); end
    n_cmp++; if (owns_uart !== 1'b1) begin n_err++; $display("FAIL halt_owns: got %b want 1", owns_uart); end
    n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'h2E) begin n_err++; $display("FAIL halt_reply: got %0d tx first %h want 1 tx 2e", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx); end
  endtask

  task automatic test_unknown();
    logic [7:0] b, ck;
    int a;
    clear_obs();
    do b = 8'($urandom); while (b == 8'h4C || b == 8'h47);
    send(b);
    wait_tx(20);
    n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'h3F) begin n_err++; $display("FAIL unknown_reply: got %0d tx first %h want 1 tx 3f", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx); end
    @(negedge clk);
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (tx_q.size() != 1 || owns_uart !== 1'b1) begin n_err++; $display("FAIL idle_halt_ignored: got %0d tx owns %b want 1 tx owns 1", tx_q.size(), owns_uart); end
    clear_obs();
    a = $urandom_range(511);
    data_q = '{8'($urandom), 8'($urandom)};
    ck = build_exp(a);
    send_load(a);
    wait_tx(20);
    n_cmp++; if (wr_q.size() != 2 || wr_q[0] !== exp_q[0] || wr_q[1] !== exp_q[1]) begin n_err++; $display("FAIL after_unknown_writes: got %0d writes want 2 matching"
      , wr_q.size()); end
    n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== ck) begin n_err++; $display("FAIL after_unknown_reply: got %0d tx first %h want 1 tx %h", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx, ck); end
  endtask

  task automatic test_busy();
    logic [7:0] ck;
    int a;
    clear_obs();
    a = $urandom_range(511);
    data_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    ck = build_exp(a);
    is_transmitting = 1'b1;
    send_load(a);
    repeat (50) @(negedge clk);
    n_cmp++; if (tx_q.size() != 0) begin n_err++; $display("FAIL busy_hold: got %0d tx want 0", tx_q.size()); end
    send(8'($urandom));
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_q.size() != 3) begin n_err++; $display("FAIL busy_drop: got %0d writes want 3", wr_q.size()); end
    is_transmitting = 1'b0;
    wait_tx(20);
    repeat (5) @(negedge clk);
    n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== ck) begin n_err++; $display("FAIL busy_reply: got %0d tx first %h want 1 tx %h", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx, ck); end
  endtask

  task automatic test_reset_midload();
    logic [7:0] ck;
    int a;
    clear_obs();
    a = $urandom_range(511);
    data_q = '{8'($urandom), 8'($urandom), 8'h3A};
    void'(build_exp(a));
    send(8'h4C);
    send({7'd0, 1'(a >> 8)});
    send(8'(a));
    send(8'd3);
    send(data_q[0]);
    send(data_q[1]);
    n_cmp++; if (write_en !== 1'b1) begin n_err++; $display("FAIL midload_pre_we: got %b want 1", write_en); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (write_en !== 1'b0 || owns_uart !== 1'b1) begin n_err++; $display("FAIL midload_async: got we %b owns %b want we 0 owns 1", write_en, owns_uart); end
    @(negedge clk);
    rst = 1'b1;
    send(data_q[2]);
    wait_tx(20);
    n_cmp++; if (wr_q.size() != 2 || wr_q[0] !== exp_q[0] || wr_q[1] !== exp_q[1]) begin n_err++; $display("FAIL midload_writes: got %0d writes want 2 matching", wr_q.size()); end
    clear_obs();
    a = $urandom_range(511);
    data_q = '{8'($urandom)};
    ck = build_exp(a);
    send_load(a);
    wait_tx(20);
    n_cmp++; if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin n_err++; $display("FAIL post_reset_write: got %0d writes first %h want 1 write %h", wr_q.size(), wr_q.size() ? wr_q[0] : 17'hx, exp_q[0]); end
    n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== ck) begin n_err++; $display("FAIL post_reset_reply: got %0d tx first %h want 1 tx %h", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx, ck); end
  endtask

  initial begin
    test_reset();
    test_load_fixed();
    test_load_random();
    test_wrap_len0();
    test_run();
    test_unknown();
    test_busy();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Serial boot/monitor front end sitting directly upstream of the cpu.
- Consumes bytes from the UART receiver and writes program images into RAM through the write port, using a byte protocol.
- Drives the cpu start strobe and start address, then hands UART ownership to the cpu until it halts.
- Outside this block, a mux selects the RAM write port and the UART tx signals by owns_uart.

Parameters:
addr_width, 9, RAM address width; must match the cpu.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
received  in  1  one-cycle strobe: rx_byte valid
rx_byte  in  8  received byte
is_transmitting  in  1  UART transmitter busy
tx_byte  out  8  byte to transmit
transmit  out  1  one-cycle transmit strobe
waddr  out  addr_width  RAM write address
wdata  out  8  RAM write data
write_en  out  1  one-cycle RAM write strobe
startaddr  out  addr_width  cpu start address
cpu_start  out  1  one-cycle start pulse, drives the cpu rst/start input
cpu_halted  in  1  cpu halted strobe
owns_uart  out  1  1 = loader owns UART and RAM write port; 0 = cpu owns them

Behaviour:
- Reset values (rst low, asynchronous): state IDLE; tx_byte, waddr, wdata, startaddr, checksum and count all 0; transmit, write_en and cpu_start 0; owns_uart 1.
- All outputs are registered.
- transmit, write_en and cpu_start default to 0 every cycle.
- Protocol, with command bytes taken only in IDLE on received:
  - 0x4C 'L': states ADDRH, ADDRL, LEN, then DATA.
    - addr = {ADDRH[addr_width-9:0], ADDRL}; upper bits of ADDRH are ignored.
    - LEN 0 means 256 bytes; otherwise LEN bytes.
  - 0x47 'G': states GADDRH, GADDRL, then START.
  - Any other byte: queue reply 0x3F ('?') and go to TX.
- DATA, on each received byte:
  - Next cycle: waddr <= addr, wdata <= rx_byte, write_en <= 1.
  - addr <= addr+1, wrapping modulo 2^addr_width (0x1FF -> 0x000 by default).
  - checksum <= checksum + rx_byte, modulo 256.
  - count <= count-1.
  - After the last byte: queue reply = checksum and go to TX.
  - checksum is cleared on entry to ADDRH.
- START: startaddr <= GADDR value. On the next cycle:
  - cpu_start pulses 1 for exactly one cycle.
  - owns_uart <= 0.
  - state <= RUN.
- RUN:
  - received, rx_byte and is_transmitting are ignored (the cpu owns the UART); transmit is held at 0.
  - cpu_halted = 1: owns_uart <= 1, queue reply 0x2E ('.'), go to TX.
- TX:
  - Wait while is_transmitting = 1.
  - When it is 0: tx_byte <= reply and transmit <= 1 for one cycle.
  - Then one GUARD cycle (covers the transmitter busy-flag latency), then IDLE.
- Boundaries:
  - received in TX or GUARD: byte dropped.
  - cpu_halted outside RUN: ignored.
  - received and cpu_halted in the same cycle in RUN: halt is handled, byte dropped.
  - No timeout between protocol bytes; the loader waits indefinitely.
  - rst low mid-load: immediate return to reset values. write_en drops asynchronously and no further writes occur; partial data already written stays in RAM.
  - rst low in RUN: owns_uart returns to 1. The cpu is not stopped by this block.
- Latency:
  - RAM write occurs 1 cycle after the received strobe.
  - Checksum transmit occurs no earlier than 2 cycles after the last data byte, and only when is_transmitting = 0.

Test Plan:
- Load 3 bytes: send 4C 00 05 03 11 22 33 -> writes (0x005,11), (0x006,22), (0x007,33), each write_en a single cycle; then transmit of tx_byte 0x66.
- Wrap and LEN 0: send 4C 01 FF 00 followed by 256 bytes of 0x01 -> first write at 0x1FF, second at 0x000, last at 0x0FE; 256 writes total; checksum reply 0x00.
- Run: send 47 00 10 -> startaddr 0x010, one cpu_start pulse, owns_uart 0; RX bytes during RUN cause no writes; pulse cpu_halted -> owns_uart 1 and transmit of 0x2E.
- Unknown command: send 0x5A -> transmit of 0x3F; a following 4C command is then accepted normally.
- Busy transmitter: hold is_transmitting = 1 for 50 cycles after the last data byte -> transmit stays 0, then pulses once after release; a byte received during that wait causes no write.
- Reset mid-load: assert rst low after 2 of 3 data bytes -> write_en 0 immediately, owns_uart 1; a subsequent data byte causes no write; a new 4C command works.
